// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port between WB (A) and the long-latency unit (B) with a pending-write
// scoreboard and hazard flag. Optional macro REGFILE_BYPASS_EN forwards the committing write to rd1/rd2.
`timescale 1ns/1ps
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [4:0]  b_addr_i,
    input  logic [31:0] b_data_i,
    input  logic        rsv_valid_i,
    input  logic [4:0]  rsv_addr_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    output logic        hazard_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_wa_o,
    output logic [31:0] rf_wd_o,
    output logic [4:0]  rf_ra1_o,
    output logic [4:0]  rf_ra2_o,
    input  logic [31:0] rf_rd1_i,
    input  logic [31:0] rf_rd2_i
);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             stg_v_q, stg_v_d;
    logic [4:0]       stg_a_q, stg_a_d;
    logic [31:0]      stg_d_q, stg_d_d;
    logic [31:0]      busy_q, busy_d;
    logic             force_b;
    logic             byp1, byp2;

    assign force_b  = (starve_q >= CNT_W'(STARVE_LIMIT));
    assign rf_ra1_o = ra1_i;
    assign rf_ra2_o = ra2_i;
    assign rf_we_o  = stg_v_q;
    assign rf_wa_o  = stg_a_q;
    assign rf_wd_o  = stg_d_q;

    // Ready is suppressed while reset is held so no request is acknowledged then.
    always_comb begin
        a_ready_o = a_valid_i && !force_b && !rst_i;
        b_ready_o = b_valid_i && (!a_valid_i || force_b) && !rst_i;
    end

    always_comb begin
        starve_d = starve_q;
        if (!b_valid_i || b_ready_o) begin
            starve_d = '0;
        end else if (starve_q != '1) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_comb begin
        stg_v_d = 1'b0;
        stg_a_d = stg_a_q;
        stg_d_d = stg_d_q;
        if (a_ready_o) begin
            stg_v_d = (a_addr_i != 5'd0);
            stg_a_d = a_addr_i;
            stg_d_d = a_data_i;
        end else if (b_ready_o) begin
            stg_v_d = (b_addr_i != 5'd0);
            stg_a_d = b_addr_i;
            stg_d_d = b_data_i;
        end
    end

    // Clear first so a same-edge reservation of the committing register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (stg_v_q) begin
            busy_d[stg_a_q] = 1'b0;
        end
        if (rsv_valid_i && rsv_addr_i != 5'd0) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        byp1     = stg_v_q && (stg_a_q == ra1_i);
        byp2     = stg_v_q && (stg_a_q == ra2_i);
        rd1_o    = byp1 ? stg_d_q : rf_rd1_i;
        rd2_o    = byp2 ? stg_d_q : rf_rd2_i;
        hazard_o = (busy_q[ra1_i] && !byp1) || (busy_q[ra2_i] && !byp2);
    end
`else
    always_comb begin
        byp1     = 1'b0;
        byp2     = 1'b0;
        rd1_o    = rf_rd1_i;
        rd2_o    = rf_rd2_i;
        hazard_o = busy_q[ra1_i] || busy_q[ra2_i] || (byp1 && byp2);
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
            stg_v_q  <= 1'b0;
            stg_a_q  <= 5'd0;
            stg_d_q  <= 32'd0;
            busy_q   <= 32'd0;
        end else begin
            starve_q <= starve_d;
            stg_v_q  <= stg_v_d;
            stg_a_q  <= stg_a_d;
            stg_d_q  <= stg_d_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Honors REGFILE_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready, rsv_valid, hazard, rf_we;
    logic [4:0]  a_addr, b_addr, rsv_addr, ra1, ra2, rf_wa, rf_ra1, rf_ra2;
    logic [31:0] a_data, b_data, rd1, rd2, rf_wd, rf_rd1, rf_rd2;
    logic [31:0] rf_mem [32];
    int          n_checks = 0;
    int          n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
        .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1), .rd2_o(rd2), .hazard_o(hazard),
        .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
        .rf_ra1_o(rf_ra1), .rf_ra2_o(rf_ra2), .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2)
    );

    always #5 clk = ~clk;

    // Bench-side RegFile: x0 hardwired to zero.
    always @(posedge clk) if (rf_we && rf_wa != 5'd0) rf_mem[rf_wa] <= rf_wd;
    assign rf_rd1 = (rf_ra1 == 5'd0) ? 32'd0 : rf_mem[rf_ra1];
    assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'd0 : rf_mem[rf_ra2];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        rsv_valid = 0; rsv_addr = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic test_reset();
        idle();
        rsv_valid = 1; rsv_addr = 9; a_valid = 1; a_addr = 3; a_data = 32'h3333_3333; ra1 = 9;
        cyc();
        rsv_valid = 0; a_valid = 0; ra2 = 3;
        #1;
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL pre_rst_hazard got %b want 1", hazard); end
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pre_rst_we got %b want 1", rf_we); end
        #2;
        rst = 1; a_valid = 1; a_addr = 2; a_data = 32'h1083_8234;
        #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready got %b want 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", rf_we); end
        n_checks++; if (rf_wa !== 5'd0) begin n_fail++; $display("FAIL rst_wa got %0d want 0", rf_wa); end
        n_checks++; if (rf_wd !== 32'd0) begin n_fail++; $display("FAIL rst_wd got %h want 0", rf_wd); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hazard got %b want 0", hazard); end
        cyc();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_hold_we got %b want 0", rf_we); end
        #3;
        rst = 0;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_a_ready got %b want 1", a_ready); end
        cyc();
        a_valid = 0; ra1 = 2;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL post_rst_we got %b want 1", rf_we); end
        n_checks++; if (rf_wa !== 5'd2) begin n_fail++; $display("FAIL post_rst_wa got %0d want 2", rf_wa); end
        n_checks++; if (rf_wd !== 32'h1083_8234) begin n_fail++; $display("FAIL post_rst_wd got %h want 10838234", rf_wd); end
        cyc();
        n_checks++; if (rd1 !== 32'h1083_8234) begin n_fail++; $display("FAIL post_rst_rd1 got %h want 10838234", rd1); end
        n_checks++; if (rd2 !== 32'd0) begin n_fail++; $display("FAIL rst_dropped_x3 got %h want 0", rd2); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_we_idle got %b want 0", rf_we); end
    endtask

    task automatic test_contention();
        idle();
        a_valid = 1; a_addr = 3; a_data = 32'hA3A3_A3A3;
        b_valid = 1; b_addr = 4; b_data = 32'hB4B4_B4B4;
        for (int k = 1; k <= 6; k++) begin
            #1;
            n_checks++; if (a_ready !== (k != 5)) begin n_fail++; $display("FAIL cont_a_ready cyc %0d got %b want %b", k, a_ready, k != 5); end
            n_checks++; if (b_ready !== (k == 5)) begin n_fail++; $display("FAIL cont_b_ready cyc %0d got %b want %b", k, b_ready, k == 5); end
            cyc();
            if (k == 5) begin
                n_checks++; if (rf_wa !== 5'd4 || rf_wd !== 32'hB4B4_B4B4) begin n_fail++; $display("FAIL cont_b_write got %0d/%h want 4/b4b4b4b4", rf_wa, rf_wd); end
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_x0();
        idle();
        b_valid = 1; b_addr = 0; b_data = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL x0_b_ready got %b want 1", b_ready); end
        cyc();
        b_valid = 0; ra1 = 0;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got %b want 0", rf_we); end
        #1;
        n_checks++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL x0_rd1 got %h want 0", rd1); end
        cyc();
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_valid = 1; rsv_addr = 5;
        cyc();
        rsv_valid = 0; ra1 = 5;
        #1;
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_set got %b want 1", hazard); end
        b_valid = 1; b_addr = 5; b_data = 32'hFEED_ABBA;
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL sb_b_ready got %b want 1", b_ready); end
        cyc();
        b_valid = 0;
        #1;
        n_checks++; if (hazard !== !BYP) begin n_fail++; $display("FAIL sb_hazard_commit got %b want %b", hazard, !BYP); end
        cyc();
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clear got %b want 0", hazard); end
        n_checks++; if (rd1 !== 32'hFEED_ABBA) begin n_fail++; $display("FAIL sb_rd1 got %h want feedabba", rd1); end
        rsv_valid = 1; rsv_addr = 6; b_valid = 1; b_addr = 6; b_data = 32'h0000_0066;
        cyc();
        b_valid = 0;
        cyc();
        rsv_valid = 0; ra1 = 6;
        #1;
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_same_edge got %b want 1", hazard); end
        b_valid = 1; b_data = 32'h0000_0067;
        cyc();
        b_valid = 0;
        cyc();
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_x6_clear got %b want 0", hazard); end
    endtask

    task automatic test_bypass();
        idle();
        a_valid = 1; a_addr = 7; a_data = 32'h1111_1111;
        cyc();
        a_valid = 0;
        cyc();
        rsv_valid = 1; rsv_addr = 7;
        cyc();
        rsv_valid = 0; a_valid = 1; a_data = 32'hCAFE_F00D;
        cyc();
        a_valid = 0; ra1 = 7; ra2 = 7;
        #1;
        n_checks++; if (rd1 !== (BYP ? 32'hCAFE_F00D : 32'h1111_1111)) begin n_fail++; $display("FAIL byp_rd1 got %h want %h", rd1, BYP ? 32'hCAFE_F00D : 32'h1111_1111); end
        n_checks++; if (rd2 !== (BYP ? 32'hCAFE_F00D : 32'h1111_1111)) begin n_fail++; $display("FAIL byp_rd2 got %h want %h", rd2, BYP ? 32'hCAFE_F00D : 32'h1111_1111); end
        n_checks++; if (hazard !== !BYP) begin n_fail++; $display("FAIL byp_hazard got %b want %b", hazard, !BYP); end
        cyc();
        n_checks++; if (rd1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL byp_after_rd1 got %h want cafef00d", rd1); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL byp_after_hazard got %b want 0", hazard); end
    endtask

    task automatic test_random();
        logic [31:0] ref_regs [32];
        bit          ref_busy [32];
        int          refused;
        bit          pend_v, exp_a, exp_b, last_a, last_b, byp, exp_hz;
        logic [4:0]  pend_a;
        logic [31:0] pend_d, exp_rd1, exp_rd2;
        idle();
        rst = 1;
        cyc();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = (i == 0) ? 32'd0 : rf_mem[i];
            ref_busy[i] = 0;
        end
        refused = 0; pend_v = 0; pend_a = 0; pend_d = 0; last_a = 0; last_b = 0;
        for (int n = 0; n < 400; n++) begin
            // A stalled requester keeps its request unchanged.
            if (!(a_valid && !last_a)) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr = 5'($urandom_range(0, 7)); a_data = $urandom;
            end
            if (!(b_valid && !last_b)) begin
                b_valid = ($urandom_range(0, 1) != 0);
                b_addr = 5'($urandom_range(0, 7)); b_data = $urandom;
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            #1;
            exp_a = a_valid && (refused < LIMIT);
            exp_b = b_valid && !exp_a;
            exp_hz = 0;
            byp = BYP && pend_v && (pend_a == ra1);
            exp_rd1 = byp ? pend_d : ref_regs[ra1];
            if (ref_busy[ra1] && !byp) exp_hz = 1;
            byp = BYP && pend_v && (pend_a == ra2);
            exp_rd2 = byp ? pend_d : ref_regs[ra2];
            if (ref_busy[ra2] && !byp) exp_hz = 1;
            n_checks++; if (a_ready !== exp_a) begin n_fail++; $display("FAIL rnd_a_ready cyc %0d got %b want %b", n, a_ready, exp_a); end
            n_checks++; if (b_ready !== exp_b) begin n_fail++; $display("FAIL rnd_b_ready cyc %0d got %b want %b", n, b_ready, exp_b); end
            n_checks++; if (hazard !== exp_hz) begin n_fail++; $display("FAIL rnd_hazard cyc %0d got %b want %b", n, hazard, exp_hz); end
            n_checks++; if (rd1 !== exp_rd1) begin n_fail++; $display("FAIL rnd_rd1 cyc %0d got %h want %h", n, rd1, exp_rd1); end
            n_checks++; if (rd2 !== exp_rd2) begin n_fail++; $display("FAIL rnd_rd2 cyc %0d got %h want %h", n, rd2, exp_rd2); end
            if (pend_v) begin
                ref_regs[pend_a] = pend_d;
                ref_busy[pend_a] = 0;
            end
            if (rsv_valid && rsv_addr != 0) ref_busy[rsv_addr] = 1;
            pend_v = 0;
            if (exp_a) begin
                pend_v = (a_addr != 0); pend_a = a_addr; pend_d = a_data;
            end else if (exp_b) begin
                pend_v = (b_addr != 0); pend_a = b_addr; pend_d = b_data;
            end
            refused = (b_valid && !exp_b) ? refused + 1 : 0;
            last_a = exp_a; last_b = exp_b;
            cyc();
            n_checks++; if (rf_we !== pend_v) begin n_fail++; $display("FAIL rnd_we cyc %0d got %b want %b", n, rf_we, pend_v); end
            if (pend_v) begin
                n_checks++; if (rf_wa !== pend_a || rf_wd !== pend_d) begin n_fail++; $display("FAIL rnd_wr cyc %0d got %0d/%h want %0d/%h", n, rf_wa, rf_wd, pend_a, pend_d); end
            end
        end
        idle();
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rst = 1;
        idle();
        repeat (2) cyc();
        rst = 0;
        cyc();
        test_reset();
        test_contention();
        test_x0();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
